// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register for an in-order core. It captures the decoded
//   instruction bundle and detects a load-use hazard against the instruction
//   already sitting in EX. On a hazard it inserts a bubble and counts it.
//
//   Optional feature (compile-time macro ID_EX_WB_BYPASS_EN):
//     defined   -> writeback data is forwarded into rs1/rs2 data at capture
//                  time, and the held operands are refreshed while stalled.
//     undefined -> operands always come from the register-file read ports.
//                  The writeback port is present but unused.
//
//   Update priority on every enabled edge:
//     flush > stall > load-use bubble > capture
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_clk_enable          global advance enable; 0 freezes every register
//   i_stall               hold request from downstream
//   i_flush               squash request (taken branch/jump)
//   i_valid               decode slot holds an instruction
//   i_pc, i_imm           decode PC and immediate
//   i_rs1/rs2/rd_addr     decoded register indices
//   i_rd_data_1/2         register-file read data
//   i_ctrl                decoded control bundle (CTRL_W bits)
//   i_wb_*                writeback port (same signals as the RF write port)
//   o_*                   registered EX-stage bundle
//   o_load_use            combinational: upstream must hold PC and IF/ID
//   o_bubble_cnt          saturating count of inserted load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int CTRL_W     = 16,
  parameter int MEM_RD_BIT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clk_enable,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [31:0]       i_pc,
  input  logic [31:0]       i_imm,
  input  logic [4:0]        i_rs1_addr,
  input  logic [4:0]        i_rs2_addr,
  input  logic [4:0]        i_rd_addr,
  input  logic [31:0]       i_rd_data_1,
  input  logic [31:0]       i_rd_data_2,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_wb_reg_write,
  input  logic [4:0]        i_wb_addr,
  input  logic [31:0]       i_wb_data,
  output logic              o_valid,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_imm,
  output logic [4:0]        o_rs1_addr,
  output logic [4:0]        o_rs2_addr,
  output logic [4:0]        o_rd_addr,
  output logic [31:0]       o_rs1_data,
  output logic [31:0]       o_rs2_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_load_use,
  output logic [15:0]       o_bubble_cnt
);

  // Operand values loaded on a capture edge and on a stall edge.
  logic [31:0] cap_rs1_data;
  logic [31:0] cap_rs2_data;
  logic [31:0] hold_rs1_data;
  logic [31:0] hold_rs2_data;

`ifdef ID_EX_WB_BYPASS_EN
  // A write to x0 is never forwarded; requiring a non-zero address here
  // also guarantees rs=0 always reads the register-file port.
  logic wb_live;
  assign wb_live = i_wb_reg_write && (i_wb_addr != 5'd0);

  assign cap_rs1_data  = (wb_live && (i_wb_addr == i_rs1_addr)) ? i_wb_data : i_rd_data_1;
  assign cap_rs2_data  = (wb_live && (i_wb_addr == i_rs2_addr)) ? i_wb_data : i_rd_data_2;
  assign hold_rs1_data = (wb_live && (i_wb_addr == o_rs1_addr)) ? i_wb_data : o_rs1_data;
  assign hold_rs2_data = (wb_live && (i_wb_addr == o_rs2_addr)) ? i_wb_data : o_rs2_data;
`else
  assign cap_rs1_data  = i_rd_data_1;
  assign cap_rs2_data  = i_rd_data_2;
  assign hold_rs1_data = o_rs1_data;
  assign hold_rs2_data = o_rs2_data;

  // Writeback port is intentionally ignored in this build.
  logic unused_wb;
  assign unused_wb = ^{i_wb_reg_write, i_wb_addr, i_wb_data};
`endif

  // Load in EX whose destination is a source of the instruction in decode.
  // Suppressed under stall/flush so those requests keep their priority.
  assign o_load_use = i_valid && o_valid && o_ctrl[MEM_RD_BIT]
                      && (o_rd_addr != 5'd0)
                      && ((o_rd_addr == i_rs1_addr) || (o_rd_addr == i_rs2_addr))
                      && !i_stall && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_pc         <= '0;
      o_imm        <= '0;
      o_rs1_addr   <= '0;
      o_rs2_addr   <= '0;
      o_rd_addr    <= '0;
      o_rs1_data   <= '0;
      o_rs2_data   <= '0;
      o_ctrl       <= '0;
      o_bubble_cnt <= '0;
    end else if (i_clk_enable) begin
      if (i_flush || o_load_use) begin
        // Squash and bubble both load an all-zero, invalid slot.
        o_valid    <= 1'b0;
        o_pc       <= '0;
        o_imm      <= '0;
        o_rs1_addr <= '0;
        o_rs2_addr <= '0;
        o_rd_addr  <= '0;
        o_rs1_data <= '0;
        o_rs2_data <= '0;
        o_ctrl     <= '0;
        // o_load_use already excludes flush, so only real bubbles count.
        if (o_load_use && (o_bubble_cnt != 16'hFFFF)) begin
          o_bubble_cnt <= o_bubble_cnt + 16'd1;
        end
      end else if (i_stall) begin
        o_rs1_data <= hold_rs1_data;
        o_rs2_data <= hold_rs2_data;
      end else begin
        o_valid    <= i_valid;
        o_pc       <= i_pc;
        o_imm      <= i_imm;
        o_rs1_addr <= i_rs1_addr;
        o_rs2_addr <= i_rs2_addr;
        o_rd_addr  <= i_rd_addr;
        o_rs1_data <= cap_rs1_data;
        o_rs2_data <= cap_rs2_data;
        // An empty slot must not carry control bits that could act in EX.
        o_ctrl     <= i_valid ? i_ctrl : '0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed testbench for id_ex_stage. Each scenario task drives its own
//   stimulus and compares outputs against hand-computed values. Inputs are
//   driven 1ns after a rising edge; outputs are sampled 1ns after the edge.
//   Expectations for forwarding follow ID_EX_WB_BYPASS_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int CTRL_W     = 16;
  localparam int MEM_RD_BIT = 1;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_clk_enable;
  logic              i_stall;
  logic              i_flush;
  logic              i_valid;
  logic [31:0]       i_pc;
  logic [31:0]       i_imm;
  logic [4:0]        i_rs1_addr;
  logic [4:0]        i_rs2_addr;
  logic [4:0]        i_rd_addr;
  logic [31:0]       i_rd_data_1;
  logic [31:0]       i_rd_data_2;
  logic [CTRL_W-1:0] i_ctrl;
  logic              i_wb_reg_write;
  logic [4:0]        i_wb_addr;
  logic [31:0]       i_wb_data;
  logic              o_valid;
  logic [31:0]       o_pc;
  logic [31:0]       o_imm;
  logic [4:0]        o_rs1_addr;
  logic [4:0]        o_rs2_addr;
  logic [4:0]        o_rd_addr;
  logic [31:0]       o_rs1_data;
  logic [31:0]       o_rs2_data;
  logic [CTRL_W-1:0] o_ctrl;
  logic              o_load_use;
  logic [15:0]       o_bubble_cnt;

  int checks = 0;
  int errors = 0;

`ifdef ID_EX_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  id_ex_stage #(.CTRL_W(CTRL_W), .MEM_RD_BIT(MEM_RD_BIT)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_clk_enable  (i_clk_enable),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .i_valid       (i_valid),
    .i_pc          (i_pc),
    .i_imm         (i_imm),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .i_rd_addr     (i_rd_addr),
    .i_rd_data_1   (i_rd_data_1),
    .i_rd_data_2   (i_rd_data_2),
    .i_ctrl        (i_ctrl),
    .i_wb_reg_write(i_wb_reg_write),
    .i_wb_addr     (i_wb_addr),
    .i_wb_data     (i_wb_data),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_imm         (o_imm),
    .o_rs1_addr    (o_rs1_addr),
    .o_rs2_addr    (o_rs2_addr),
    .o_rd_addr     (o_rd_addr),
    .o_rs1_data    (o_rs1_data),
    .o_rs2_data    (o_rs2_data),
    .o_ctrl        (o_ctrl),
    .o_load_use    (o_load_use),
    .o_bubble_cnt  (o_bubble_cnt)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_slot(input logic valid, input logic [31:0] pc,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [15:0] ctrl);
    i_valid     = valid;
    i_pc        = pc;
    i_imm       = pc + 32'h10;
    i_rs1_addr  = rs1;
    i_rs2_addr  = rs2;
    i_rd_addr   = rd;
    i_rd_data_1 = d1;
    i_rd_data_2 = d2;
    i_ctrl      = ctrl;
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
    i_wb_reg_write = we;
    i_wb_addr      = addr;
    i_wb_data      = data;
  endtask

  task automatic drive_idle();
    i_clk_enable = 1'b1;
    i_stall      = 1'b0;
    i_flush      = 1'b0;
    drive_slot(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0);
    drive_wb(1'b0, 5'd0, 32'h0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst_n = 1'b0;
    drive_idle();
    drive_slot(1'b1, 32'h9999, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'hFFFF);
    tick();
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", o_pc); end
    checks++; if (o_ctrl !== 16'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", o_ctrl); end
    checks++; if (o_bubble_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", o_bubble_cnt); end
    i_rst_n = 1'b1;
    drive_idle();
  endtask

  task automatic test_capture();
    drive_slot(1'b1, 32'h100, 5'd3, 5'd4, 5'd6, 32'hAAAA, 32'hBBBB, 16'h0005);
    tick();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL cap_valid: got %b expected 1", o_valid); end
    checks++; if (o_pc !== 32'h100) begin errors++; $display("FAIL cap_pc: got %h expected 100", o_pc); end
    checks++; if (o_imm !== 32'h110) begin errors++; $display("FAIL cap_imm: got %h expected 110", o_imm); end
    checks++; if (o_rs1_data !== 32'hAAAA) begin errors++; $display("FAIL cap_rs1_data: got %h expected aaaa", o_rs1_data); end
    checks++; if (o_rs2_data !== 32'hBBBB) begin errors++; $display("FAIL cap_rs2_data: got %h expected bbbb", o_rs2_data); end
    checks++; if ({o_rs1_addr, o_rs2_addr, o_rd_addr} !== {5'd3, 5'd4, 5'd6}) begin
      errors++; $display("FAIL cap_addrs: got %0d/%0d/%0d expected 3/4/6", o_rs1_addr, o_rs2_addr, o_rd_addr); end
    checks++; if (o_ctrl !== 16'h0005) begin errors++; $display("FAIL cap_ctrl: got %h expected 0005", o_ctrl); end
  endtask

  task automatic test_invalid_capture();
    drive_slot(1'b0, 32'h200, 5'd8, 5'd9, 5'd10, 32'h1234, 32'h5678, 16'hFFFF);
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL inv_valid: got %b expected 0", o_valid); end
    checks++; if (o_ctrl !== 16'h0) begin errors++; $display("FAIL inv_ctrl: got %h expected 0", o_ctrl); end
    checks++; if (o_pc !== 32'h200) begin errors++; $display("FAIL inv_pc: got %h expected 200", o_pc); end
    checks++; if (o_rd_addr !== 5'd10) begin errors++; $display("FAIL inv_rd: got %0d expected 10", o_rd_addr); end
  endtask

  task automatic test_clk_enable();
    i_clk_enable = 1'b0;
    drive_slot(1'b1, 32'h2A0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0001);
    tick();
    tick();
    checks++; if (o_pc !== 32'h200) begin errors++; $display("FAIL en_hold_pc: got %h expected 200", o_pc); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL en_hold_valid: got %b expected 0", o_valid); end
    i_clk_enable = 1'b1;
    tick();
    checks++; if (o_pc !== 32'h2A0) begin errors++; $display("FAIL en_resume_pc: got %h expected 2a0", o_pc); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rs1;
    // Same-cycle writeback to a source register.
    drive_slot(1'b1, 32'h300, 5'd5, 5'd6, 5'd11, 32'h1, 32'h22, 16'h0);
    drive_wb(1'b1, 5'd5, 32'hDEAD);
    exp_rs1 = BYPASS ? 32'hDEAD : 32'h1;
    tick();
    checks++; if (o_rs1_data !== exp_rs1) begin errors++; $display("FAIL byp_rs1: got %h expected %h", o_rs1_data, exp_rs1); end
    checks++; if (o_rs2_data !== 32'h22) begin errors++; $display("FAIL byp_rs2_indep: got %h expected 22", o_rs2_data); end
    // Writes to x0 are never forwarded.
    drive_slot(1'b1, 32'h304, 5'd0, 5'd0, 5'd11, 32'h77, 32'h88, 16'h0);
    drive_wb(1'b1, 5'd0, 32'hDEAD);
    tick();
    checks++; if (o_rs1_data !== 32'h77) begin errors++; $display("FAIL byp_x0_rs1: got %h expected 77", o_rs1_data); end
    checks++; if (o_rs2_data !== 32'h88) begin errors++; $display("FAIL byp_x0_rs2: got %h expected 88", o_rs2_data); end
    // Write enable low: no forwarding even on an address match.
    drive_slot(1'b1, 32'h308, 5'd12, 5'd13, 5'd11, 32'h3, 32'h4, 16'h0);
    drive_wb(1'b0, 5'd13, 32'hBEEF);
    tick();
    checks++; if (o_rs2_data !== 32'h4) begin errors++; $display("FAIL byp_we_low: got %h expected 4", o_rs2_data); end
    drive_wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_load_use();
    drive_slot(1'b1, 32'h400, 5'd1, 5'd2, 5'd7, 32'h10, 32'h20, 16'h0002);
    tick();
    drive_slot(1'b1, 32'h404, 5'd1, 5'd7, 5'd8, 32'h30, 32'h40, 16'h0001);
    #1;
    checks++; if (o_load_use !== 1'b1) begin errors++; $display("FAIL lu_detect: got %b expected 1", o_load_use); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble_valid: got %b expected 0", o_valid); end
    checks++; if ({o_ctrl, o_rd_addr} !== 21'h0) begin errors++; $display("FAIL lu_bubble_zero: got %h/%0d expected 0/0", o_ctrl, o_rd_addr); end
    checks++; if (o_bubble_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", o_bubble_cnt); end
    checks++; if (o_load_use !== 1'b0) begin errors++; $display("FAIL lu_clear: got %b expected 0", o_load_use); end
    tick();
    checks++; if ({o_valid, o_pc} !== {1'b1, 32'h404}) begin errors++; $display("FAIL lu_resume: got %b/%h expected 1/404", o_valid, o_pc); end
    checks++; if (o_bubble_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_hold: got %0d expected 1", o_bubble_cnt); end
    // Load into x0 never creates a hazard.
    drive_slot(1'b1, 32'h410, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0002);
    tick();
    #1;
    checks++; if (o_load_use !== 1'b0) begin errors++; $display("FAIL lu_x0: got %b expected 0", o_load_use); end
  endtask

  task automatic test_stall_refresh();
    logic [31:0] exp_rs2;
    drive_slot(1'b1, 32'h500, 5'd14, 5'd9, 5'd10, 32'h66, 32'h11, 16'h0);
    tick();
    i_stall = 1'b1;
    drive_slot(1'b1, 32'h5F0, 5'd1, 5'd2, 5'd3, 32'h99, 32'h99, 16'h00FF);
    tick();
    drive_wb(1'b1, 5'd9, 32'h55);
    tick();
    drive_wb(1'b0, 5'd0, 32'h0);
    tick();
    exp_rs2 = BYPASS ? 32'h55 : 32'h11;
    checks++; if (o_rs2_data !== exp_rs2) begin errors++; $display("FAIL stall_rs2: got %h expected %h", o_rs2_data, exp_rs2); end
    checks++; if (o_rs1_data !== 32'h66) begin errors++; $display("FAIL stall_rs1: got %h expected 66", o_rs1_data); end
    checks++; if ({o_valid, o_pc, o_rd_addr, o_ctrl} !== {1'b1, 32'h500, 5'd10, 16'h0}) begin
      errors++; $display("FAIL stall_hold: got %b/%h/%0d/%h expected 1/500/10/0", o_valid, o_pc, o_rd_addr, o_ctrl); end
    i_stall = 1'b0;
  endtask

  task automatic test_priority();
    // Stall beats a would-be hazard: slot held, no bubble.
    drive_slot(1'b1, 32'h600, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 16'h0002);
    tick();
    i_stall = 1'b1;
    drive_slot(1'b1, 32'h604, 5'd7, 5'd2, 5'd3, 32'h0, 32'h0, 16'h0);
    #1;
    checks++; if (o_load_use !== 1'b0) begin errors++; $display("FAIL prio_stall_lu: got %b expected 0", o_load_use); end
    tick();
    checks++; if ({o_valid, o_pc, o_bubble_cnt} !== {1'b1, 32'h600, 16'd1}) begin
      errors++; $display("FAIL prio_stall_hold: got %b/%h/%0d expected 1/600/1", o_valid, o_pc, o_bubble_cnt); end
    // Flush + stall + hazard: flush wins, counter unchanged.
    i_flush = 1'b1;
    #1;
    checks++; if (o_load_use !== 1'b0) begin errors++; $display("FAIL prio_flush_lu: got %b expected 0", o_load_use); end
    tick();
    checks++; if ({o_valid, o_pc, o_ctrl} !== {1'b0, 32'h0, 16'h0}) begin
      errors++; $display("FAIL prio_flush: got %b/%h/%h expected 0/0/0", o_valid, o_pc, o_ctrl); end
    checks++; if (o_bubble_cnt !== 16'd1) begin errors++; $display("FAIL prio_cnt: got %0d expected 1", o_bubble_cnt); end
    i_flush = 1'b0;
    i_stall = 1'b0;
  endtask

  task automatic test_async_reset();
    drive_slot(1'b1, 32'h700, 5'd2, 5'd3, 5'd4, 32'h12, 32'h34, 16'h0003);
    tick();
    i_stall = 1'b1;
    tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if ({o_valid, o_pc, o_rs1_data, o_ctrl} !== {1'b0, 32'h0, 32'h0, 16'h0}) begin
      errors++; $display("FAIL async_rst: got %b/%h/%h/%h expected all 0", o_valid, o_pc, o_rs1_data, o_ctrl); end
    checks++; if (o_bubble_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_cnt: got %0d expected 0", o_bubble_cnt); end
    #1;
    i_rst_n = 1'b1;
    i_stall = 1'b0;
    drive_slot(1'b1, 32'h780, 5'd2, 5'd3, 5'd4, 32'h12, 32'h34, 16'h0);
    tick();
    checks++; if ({o_valid, o_pc} !== {1'b1, 32'h780}) begin errors++; $display("FAIL post_rst_cap: got %b/%h expected 1/780", o_valid, o_pc); end
  endtask

  task automatic test_saturation();
    drive_slot(1'b1, 32'h800, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 16'h0002);
    tick();
    // Preload the counter near its ceiling while the pipeline is frozen.
    i_clk_enable = 1'b0;
    force dut.o_bubble_cnt = 16'hFFFE;
    #1;
    release dut.o_bubble_cnt;
    #1;
    checks++; if (o_bubble_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preload: got %h expected fffe", o_bubble_cnt); end
    i_clk_enable = 1'b1;
    drive_slot(1'b1, 32'h804, 5'd7, 5'd0, 5'd3, 32'h0, 32'h0, 16'h0);
    tick();
    checks++; if (o_bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_inc: got %h expected ffff", o_bubble_cnt); end
    drive_slot(1'b1, 32'h808, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 16'h0002);
    tick();
    drive_slot(1'b1, 32'h80C, 5'd0, 5'd7, 5'd3, 32'h0, 32'h0, 16'h0);
    #1;
    checks++; if (o_load_use !== 1'b1) begin errors++; $display("FAIL sat_lu: got %b expected 1", o_load_use); end
    tick();
    checks++; if (o_bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", o_bubble_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_capture();
    test_invalid_capture();
    test_clk_enable();
    test_bypass();
    test_load_use();
    test_stall_refresh();
    test_priority();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
